// File: rtl/cic_pkg.sv
// Shared CIC constants and the output-width rule, used by both the integrator
// and comb halves so that their stage counts and widths stay in step.
package cic_pkg;

    localparam int CIC_IW    = 8;
    localparam int CIC_N     = 3;
    localparam int CIC_R_MAX = 16;

    // Bit growth of an N-stage CIC at the largest ratio (differential delay 1).
    function automatic int cic_out_width(input int iw, input int n, input int r_max);
        return iw + n * $clog2(r_max);
    endfunction

endpackage

// File: rtl/cic_integrator.sv
// One OW-bit enabled accumulator of the CIC integrator cascade; wraps modulo 2^OW.
module cic_integrator #(
    parameter int OW = 20
) (
    input  logic          i_clk,
    input  logic          i_reset_n,
    input  logic          i_ce,
    input  logic [OW-1:0] i_in,
    output logic [OW-1:0] o_sum
);

    logic [OW-1:0] sum_q;
    logic [OW-1:0] sum_d;

    always_comb begin
        sum_d = sum_q;
        if (i_ce) begin
            sum_d = sum_q + i_in;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign o_sum = sum_q;

endmodule

// File: rtl/cic_integrator_decimator.sv
// CIC integrator cascade followed by a runtime-programmable rate-R decimator;
// o_ready strobes once per decimated word and feeds the comb cascade's i_ce.
module cic_integrator_decimator
    import cic_pkg::*;
#(
    parameter int IW    = CIC_IW,
    parameter int N     = CIC_N,
    parameter int R_MAX = CIC_R_MAX,
    parameter int RW    = 5,
    parameter int OW    = cic_out_width(CIC_IW, CIC_N, CIC_R_MAX)
) (
    input  logic          i_clk,
    input  logic          i_reset_n,
    input  logic          i_ce,
    input  logic [IW-1:0] i_data,
    input  logic [RW-1:0] i_ratio,
    output logic [OW-1:0] o_data,
    output logic          o_ready
);

    localparam int AW = $clog2(R_MAX + 1);

    if (OW < cic_out_width(IW, N, R_MAX)) begin : g_width_check
        $error("cic_integrator_decimator: OW too small for IW, N and R_MAX");
    end

    logic [OW-1:0] data_ext;
    logic [OW-1:0] acc [N];

    assign data_ext = {{(OW-IW){i_data[IW-1]}}, i_data};

    for (genvar g = 0; g < N; g++) begin : g_stage
        logic [OW-1:0] stage_in;
        if (g == 0) begin : g_first
            assign stage_in = data_ext;
        end else begin : g_rest
            assign stage_in = acc[g-1];
        end
        cic_integrator #(.OW(OW)) u_integrator (
            .i_clk     (i_clk),
            .i_reset_n (i_reset_n),
            .i_ce      (i_ce),
            .i_in      (stage_in),
            .o_sum     (acc[g])
        );
    end

    logic [AW-1:0] r_active_q, r_active_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          first_q, first_d;
    logic          pending_q, pending_d;
    logic [OW-1:0] o_data_q, o_data_d;
    logic          o_ready_q, o_ready_d;

    logic [AW-1:0] ratio_san;
    logic [AW-1:0] r_eff;
    logic          dec;

    always_comb begin
        ratio_san = AW'(i_ratio);
        if (i_ratio == '0) begin
            ratio_san = AW'(1);
        end else if (32'(i_ratio) > R_MAX) begin
            ratio_san = AW'(R_MAX);
        end
    end

    // The first sample after reset opens a frame, so its ratio must already
    // govern the terminal-count compare for that same sample.
    always_comb begin
        r_eff = first_q ? ratio_san : r_active_q;
        dec   = i_ce && (cnt_q == r_eff - AW'(1));

        first_d    = first_q && !i_ce;
        r_active_d = r_active_q;
        cnt_d      = cnt_q;
        if (i_ce) begin
            if (first_q || dec) begin
                r_active_d = ratio_san;
            end
            cnt_d = dec ? '0 : cnt_q + AW'(1);
        end

        pending_d = pending_q;
        o_ready_d = 1'b0;
        o_data_d  = o_data_q;
        if (pending_q) begin
            pending_d = 1'b0;
            o_ready_d = 1'b1;
            o_data_d  = acc[N-1];
        end
        if (dec) begin
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_active_q <= AW'(1);
            cnt_q      <= '0;
            first_q    <= 1'b1;
            pending_q  <= 1'b0;
            o_data_q   <= '0;
            o_ready_q  <= 1'b0;
        end else begin
            r_active_q <= r_active_d;
            cnt_q      <= cnt_d;
            first_q    <= first_d;
            pending_q  <= pending_d;
            o_data_q   <= o_data_d;
            o_ready_q  <= o_ready_d;
        end
    end

    assign o_data  = o_data_q;
    assign o_ready = o_ready_q;

endmodule
